// File: rtl/fan_monitor_pkg.sv
// Shared constants for the fan tachometer monitor: FSM encodings,
// counter widths and saturation limits.
package fan_monitor_pkg;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ZG_W  = 4;

  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
  localparam logic [ZG_W-1:0]  ZG_SAT  = 4'hF;

  // Clamp a 32-bit speed product into the 16-bit rpm field.
  function automatic logic [CNT_W-1:0] sat16(input logic [31:0] v);
    return (v > 32'(CNT_SAT)) ? CNT_SAT : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fan_tach_channel.sv
// One tachometer channel: synchroniser, glitch filter, gated edge counter
// and zero-gate (stall) tracking.
module fan_tach_channel
  import fan_monitor_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned STALL_GATES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tach,
  input  logic             gate_end,
  output logic [CNT_W-1:0] count_c,
  output logic             stall_nxt_c,
  output logic             stall
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  filt_nxt;
  logic                  rise_c;
  logic [CNT_W-1:0]      cnt_q;
  logic [ZG_W-1:0]       zg_q;
  logic [ZG_W-1:0]       zg_nxt;

  // Level only changes once the whole history window agrees.
  always_comb begin
    filt_nxt = filt_q;
    if (&hist_q) begin
      filt_nxt = 1'b1;
    end else if (~|hist_q) begin
      filt_nxt = 1'b0;
    end
  end

  assign rise_c  = filt_nxt & ~filt_q;
  assign count_c = (rise_c && (cnt_q != CNT_SAT)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    zg_nxt = '0;
    if (count_c == '0) begin
      zg_nxt = (zg_q == ZG_SAT) ? ZG_SAT : zg_q + ZG_W'(1);
    end
  end

  assign stall_nxt_c = (zg_nxt >= ZG_W'(STALL_GATES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      zg_q   <= '0;
      stall  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tach};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      filt_q <= filt_nxt;
      if (gate_end) begin
        cnt_q <= '0;
        zg_q  <= zg_nxt;
        stall <= stall_nxt_c;
      end else begin
        cnt_q <= count_c;
      end
    end
  end

endmodule

// File: rtl/fan_monitor.sv
// Multi-channel fan speed monitor: gated tach edge counting, rpm scaling,
// stall detection and sticky low-speed alarms with a maskable interrupt.
module fan_monitor
  import fan_monitor_pkg::*;
#(
  parameter int unsigned NUM_FANS       = 4,
  parameter int unsigned REFCLK_HZ      = 187500000,
  parameter int unsigned GATE_MS        = 500,
  parameter int unsigned PULSES_PER_REV = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned STALL_GATES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_FANS-1:0]       tach,
  input  logic [CNT_W*NUM_FANS-1:0] rpm_min,
  input  logic [NUM_FANS-1:0]       alarm_mask,
  input  logic [NUM_FANS-1:0]       alarm_clr,
  output logic [CNT_W*NUM_FANS-1:0] rpm,
  output logic                      rpm_update,
  output logic                      rpm_valid,
  output logic [NUM_FANS-1:0]       stall,
  output logic [NUM_FANS-1:0]       alarm,
  output logic                      irq
);

  localparam longint unsigned GATE_CYCLES_L = (64'(REFCLK_HZ) * 64'(GATE_MS)) / 64'd1000;
  localparam int unsigned     GATE_CYCLES   = 32'(GATE_CYCLES_L);
  localparam int unsigned     TMR_W         = $clog2(GATE_CYCLES + 1);
  localparam int unsigned     REV_DIV       = GATE_MS * PULSES_PER_REV;
  localparam int unsigned     RPM_SCALE     = 32'd60000 / REV_DIV;

  if ((32'd60000 % REV_DIV) != 0) begin : g_bad_scale
    $error("fan_monitor: 60000/(GATE_MS*PULSES_PER_REV) must be an integer");
  end

  logic [TMR_W-1:0]          tmr_q;
  logic                      gate_end_c;
  logic [CNT_W*NUM_FANS-1:0] count_c;
  logic [NUM_FANS-1:0]       stall_nxt_c;
  logic [0:0]                state_q;
  logic [0:0]                state_nxt;
  logic [CNT_W*NUM_FANS-1:0] rpm_nxt;
  logic [NUM_FANS-1:0]       alarm_nxt;

  assign gate_end_c = (tmr_q == TMR_W'(GATE_CYCLES - 1));

  // Shared gate timer; the terminal cycle still belongs to the closing gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (gate_end_c) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_ch
    fan_tach_channel #(
      .FILTER_LEN  (FILTER_LEN),
      .STALL_GATES (STALL_GATES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tach        (tach[i]),
      .gate_end    (gate_end_c),
      .count_c     (count_c[CNT_W*i +: CNT_W]),
      .stall_nxt_c (stall_nxt_c[i]),
      .stall       (stall[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Alarms are only judged once a previous gate has established a baseline.
  always_comb begin
    state_nxt = state_q;
    rpm_nxt   = rpm;
    alarm_nxt = alarm & ~alarm_clr;
    if (gate_end_c) begin
      state_nxt = ST_RUN;
      for (int i = 0; i < NUM_FANS; i++) begin
        rpm_nxt[CNT_W*i +: CNT_W] = sat16(32'(count_c[CNT_W*i +: CNT_W]) * 32'(RPM_SCALE));
        if ((state_q == ST_RUN) &&
            ((rpm_nxt[CNT_W*i +: CNT_W] < rpm_min[CNT_W*i +: CNT_W]) || stall_nxt_c[i])) begin
          alarm_nxt[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpm        <= '0;
      rpm_update <= 1'b0;
      alarm      <= '0;
      irq        <= 1'b0;
    end else begin
      rpm        <= rpm_nxt;
      rpm_update <= gate_end_c;
      alarm      <= alarm_nxt;
      irq        <= |(alarm & alarm_mask);
    end
  end

  assign rpm_valid = (state_q == ST_RUN);

endmodule

// File: tb/tb_fan_monitor.sv
// Scoreboard bench for fan_monitor: per-gate expectations are queued when
// the tach patterns are configured and compared on each rpm_update.
module tb_fan_monitor;

  localparam int unsigned NF = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NF-1:0]   tach = '0;
  logic [16*NF-1:0] rpm_min = '0;
  logic [NF-1:0]   alarm_mask = '0;
  logic [NF-1:0]   alarm_clr = '0;
  logic [16*NF-1:0] rpm;
  logic            rpm_update, rpm_valid, irq;
  logic [NF-1:0]   stall, alarm;

  logic            tach_s = 1'b0;
  logic [15:0]     rpm_min_s = '0;
  logic            mask_s = 1'b0;
  logic            clr_s = 1'b0;
  logic [15:0]     rpm_s;
  logic            rpm_update_s, rpm_valid_s, stall_s, alarm_s, irq_s;

  always #5 clk = ~clk;

  fan_monitor #(
    .NUM_FANS(NF), .REFCLK_HZ(1000), .GATE_MS(500), .PULSES_PER_REV(2),
    .FILTER_LEN(4), .STALL_GATES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tach(tach), .rpm_min(rpm_min),
    .alarm_mask(alarm_mask), .alarm_clr(alarm_clr), .rpm(rpm),
    .rpm_update(rpm_update), .rpm_valid(rpm_valid), .stall(stall),
    .alarm(alarm), .irq(irq)
  );

  // 5000-cycle gate so a fast fan overflows the 16-bit rpm field.
  fan_monitor #(
    .NUM_FANS(1), .REFCLK_HZ(10000), .GATE_MS(500), .PULSES_PER_REV(2),
    .FILTER_LEN(2), .STALL_GATES(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .tach(tach_s), .rpm_min(rpm_min_s),
    .alarm_mask(mask_s), .alarm_clr(clr_s), .rpm(rpm_s),
    .rpm_update(rpm_update_s), .rpm_valid(rpm_valid_s), .stall(stall_s),
    .alarm(alarm_s), .irq(irq_s)
  );

  // Tach pattern per channel: 0 = held low, 1 = square of period per[i], 2 = 2-cycle pulse every 20
  int unsigned mode [NF];
  int unsigned per  [NF];
  int unsigned ph = 0;

  function automatic logic gen(input int unsigned m, input int unsigned p, input int unsigned t);
    if (m == 1) return (t % p) >= (p / 2);
    if (m == 2) return (t % 20) < 2;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) ph = 0;
      else ph++;
      for (int i = 0; i < NF; i++) tach[i] = gen(mode[i], per[i], ph);
      tach_s = (ph % 4) >= 2;
    end
  end

  typedef struct {
    logic [16*NF-1:0] rpm;
    logic             valid;
    logic [NF-1:0]    stall;
    logic [NF-1:0]    alarm;
  } exp_t;

  exp_t            sb_q[$];
  logic [15:0]     sat_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int unsigned     m_zg [NF];
  logic            m_run;
  logic [NF-1:0]   m_alarm;

  task automatic model_reset();
    m_run   = 1'b0;
    m_alarm = '0;
    for (int i = 0; i < NF; i++) m_zg[i] = 0;
    sb_q.delete();
  endtask

  // Expected outputs for one full gate under the current tach patterns.
  task automatic push_gate();
    exp_t e;
    int unsigned edges, r;
    for (int i = 0; i < NF; i++) begin
      edges = (mode[i] == 1) ? 500 / per[i] : 0;
      r = edges * 60;
      if (r > 65535) r = 65535;
      e.rpm[16*i +: 16] = 16'(r);
      if (edges == 0) m_zg[i] = (m_zg[i] < 15) ? m_zg[i] + 1 : 15;
      else m_zg[i] = 0;
      e.stall[i] = (m_zg[i] >= 2);
      if (m_run && ((16'(r) < rpm_min[16*i +: 16]) || e.stall[i])) m_alarm[i] = 1'b1;
    end
    m_run   = 1'b1;
    e.valid = 1'b1;
    e.alarm = m_alarm;
    sb_q.push_back(e);
  endtask

  task automatic wait_update(input int unsigned budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < int'(budget) && !seen; c++) begin
      @(negedge clk);
      if (rpm_update === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NF; i++) begin mode[i] = 0; per[i] = 50; end
    repeat (3) @(negedge clk);
    n_vec++; if (rpm !== '0) begin n_err++; $display("FAIL reset_rpm: got %h want 0", rpm); end
    n_vec++; if (rpm_update !== 1'b0) begin n_err++; $display("FAIL reset_update: got %b want 0", rpm_update); end
    n_vec++; if (rpm_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rpm_valid); end
    n_vec++; if (stall !== '0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++; if (alarm !== '0) begin n_err++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++; if (rpm_s !== '0) begin n_err++; $display("FAIL reset_rpm_sat: got %h want 0", rpm_s); end
  endtask

  // Square waves, a stalled fan, a glitch-only fan, warmup, sticky alarm and clear.
  task automatic test_gates_and_alarms();
    exp_t e;
    bit   seen;
    mode[0] = 1; per[0] = 50;
    mode[1] = 0;
    mode[2] = 2;
    mode[3] = 1; per[3] = 100;
    rpm_min = {16'd100, 16'd0, 16'd0, 16'd1000};
    alarm_mask = 4'b0010;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_vec++; if (rpm_valid !== 1'b0) begin n_err++; $display("FAIL warmup_valid: got %b want 0", rpm_valid); end
    for (int g = 0; g < 3; g++) begin
      if (g == 2) begin
        repeat (10) @(negedge clk);
        alarm_clr = 4'b0001;
        @(negedge clk);
        alarm_clr = '0;
        m_alarm[0] = 1'b0;
        n_vec++; if (alarm !== m_alarm) begin n_err++; $display("FAIL alarm_clr: got %b want %b", alarm, m_alarm); end
      end
      push_gate();
      wait_update(600, seen);
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL gate%0d_timeout: rpm_update got 0 want 1", g); continue; end
      e = sb_q.pop_front();
      n_vec++; if (rpm !== e.rpm) begin n_err++; $display("FAIL gate%0d_rpm: got %h want %h", g, rpm, e.rpm); end
      n_vec++; if (rpm_valid !== e.valid) begin n_err++; $display("FAIL gate%0d_valid: got %b want %b", g, rpm_valid, e.valid); end
      n_vec++; if (stall !== e.stall) begin n_err++; $display("FAIL gate%0d_stall: got %b want %b", g, stall, e.stall); end
      n_vec++; if (alarm !== e.alarm) begin n_err++; $display("FAIL gate%0d_alarm: got %b want %b", g, alarm, e.alarm); end
      if (g == 1) begin
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b want 0", irq); end
        @(negedge clk);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
      end
    end
  endtask

  // Reset asserted mid-gate clears outputs at once; next gate is a full one.
  task automatic test_reset_mid_gate();
    exp_t e;
    int   c;
    repeat (249) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (rpm !== '0) begin n_err++; $display("FAIL midrst_rpm: got %h want 0", rpm); end
    n_vec++; if (rpm_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", rpm_valid); end
    n_vec++; if (stall !== '0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", stall); end
    n_vec++; if (alarm !== '0) begin n_err++; $display("FAIL midrst_alarm: got %b want 0", alarm); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq: got %b want 0", irq); end
    repeat (2) @(negedge clk);
    model_reset();
    push_gate();
    rst_n = 1'b1;
    c = 0;
    while (c < 600) begin
      @(posedge clk);
      #1;
      c++;
      if (rpm_update === 1'b1) break;
    end
    // rpm_update is seen after 500 edges, i.e. in the 501st cycle after release
    n_vec++; if (c != 500) begin n_err++; $display("FAIL midrst_latency: got %0d edges want 500", c); end
    e = sb_q.pop_front();
    n_vec++; if (rpm !== e.rpm) begin n_err++; $display("FAIL midrst_rpm_gate: got %h want %h", rpm, e.rpm); end
    n_vec++; if (alarm !== e.alarm) begin n_err++; $display("FAIL midrst_alarm_gate: got %b want %b", alarm, e.alarm); end
    n_vec++; if (rpm_valid !== e.valid) begin n_err++; $display("FAIL midrst_valid_gate: got %b want %b", rpm_valid, e.valid); end
  endtask

  task automatic test_saturation();
    bit          seen;
    int unsigned r;
    logic [15:0] want;
    r = (5000 / 4) * 60;
    sat_q.push_back((r > 65535) ? 16'hFFFF : 16'(r));
    seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (rpm_update_s === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL sat_timeout: rpm_update got 0 want 1");
    end else begin
      want = sat_q.pop_front();
      n_vec++; if (rpm_s !== want) begin n_err++; $display("FAIL sat_rpm: got %h want %h", rpm_s, want); end
      n_vec++; if (rpm_valid_s !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", rpm_valid_s); end
      n_vec++; if (stall_s !== 1'b0) begin n_err++; $display("FAIL sat_stall: got %b want 0", stall_s); end
    end
  endtask

  initial begin
    test_reset();
    test_gates_and_alarms();
    test_reset_mid_gate();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
